// File: rtl/instrumentation_pkg.sv
// Shared types for the instrumentation trip latch: channel geometry, mode
// encodings, channel FSM states and the packed per-channel field accessor.
package instrumentation_pkg;

  localparam int NChannels = 3;
  localparam int lg2       = 2;
  localparam int STATE_W   = 2;

  typedef enum logic [lg2-1:0] {
    MODE_BYPASS  = 2'd0,
    MODE_OPERATE = 2'd1,
    MODE_TRIP    = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mode_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_TRIPPED = 2'd2
  } chan_state_e;

  // Channel 0 sits in the most significant field of every packed vector.
  function automatic logic [lg2-1:0] get_field(input logic [NChannels*lg2-1:0] vec,
                                               input int ch);
    return vec[lg2*(NChannels-ch)-1 -: lg2];
  endfunction

endpackage

// File: rtl/trip_latch_channel.sv
// One instrumentation channel: mode override, sensor debounce and a fail-safe
// trip latch that only clears on a maintenance reset while the sensor is quiet.
module trip_latch_channel
  import instrumentation_pkg::*;
#(
  parameter int DEBOUNCE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc,
  input  mode_e       mode,
  input  logic        sensor,
  input  logic        reset_req,
  output chan_state_e state,
  output chan_state_e state_nxt
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       rst_pend;
  logic       eff_rst;

  // A request arriving alongside the accepted sample applies to that sample.
  assign eff_rst = rst_pend | reset_req;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (mode)
      MODE_BYPASS: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      MODE_TRIP, MODE_ILLEGAL: begin
        state_nxt = ST_TRIPPED;
      end
      MODE_OPERATE: begin
        case (state)
          ST_IDLE: begin
            if (sensor) begin
              cnt_nxt   = 4'd1;
              state_nxt = (DEB == 4'd1) ? ST_TRIPPED : ST_PEND;
            end else begin
              cnt_nxt = '0;
            end
          end
          ST_PEND: begin
            if (sensor) begin
              cnt_nxt = (cnt < DEB) ? cnt + 4'd1 : DEB;
              if (cnt_nxt >= DEB) state_nxt = ST_TRIPPED;
            end else begin
              state_nxt = ST_IDLE;
              cnt_nxt   = '0;
            end
          end
          ST_TRIPPED: begin
            // An active sensor overrides the reset: the trip stays latched.
            if (eff_rst && !sensor) begin
              state_nxt = ST_IDLE;
              cnt_nxt   = '0;
            end
          end
          default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        endcase
      end
      default: begin
        state_nxt = ST_TRIPPED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rst_pend <= 1'b0;
    end else begin
      if (acc) begin
        state    <= state_nxt;
        cnt      <= cnt_nxt;
        rst_pend <= 1'b0;
      end else if (reset_req) begin
        rst_pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/instrumentation_trip_latch.sv
// Trip latch stage between the sensor comparators and the voting logic.
// Handshake: a transfer happens on a cycle where valid & ready are both high;
// valid never waits on ready, and data holds while valid & !ready.
module instrumentation_trip_latch
  import instrumentation_pkg::*;
#(
  parameter int DEBOUNCE = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic [NChannels-1:0]         sensor_trips,
  input  logic [NChannels*lg2-1:0]     modes,
  input  logic [NChannels-1:0]         reset_req,
  output logic                         trip_valid,
  input  logic                         trip_ready,
  output logic [NChannels-1:0]         trip_out,
  output logic                         mode_err,
  output logic [NChannels*STATE_W-1:0] dbg_state
);

  logic                 acc;
  logic [NChannels-1:0] trip_nxt;
  logic [NChannels-1:0] illegal;
  chan_state_e          ch_state [NChannels];
  chan_state_e          ch_nxt   [NChannels];

  assign sample_ready = !trip_valid || trip_ready;
  assign acc          = sample_valid && sample_ready;

  for (genvar g = 0; g < NChannels; g++) begin : g_chan
    mode_e ch_mode;
    assign ch_mode = mode_e'(get_field(modes, g));

    trip_latch_channel #(.DEBOUNCE(DEBOUNCE)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .acc       (acc),
      .mode      (ch_mode),
      .sensor    (sensor_trips[NChannels-1-g]),
      .reset_req (reset_req[NChannels-1-g]),
      .state     (ch_state[g]),
      .state_nxt (ch_nxt[g])
    );

    assign trip_nxt[NChannels-1-g] = (ch_nxt[g] == ST_TRIPPED);
    assign illegal[NChannels-1-g]  = (ch_mode == MODE_ILLEGAL);
    assign dbg_state[STATE_W*(NChannels-g)-1 -: STATE_W] = ch_state[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trip_valid <= 1'b0;
      trip_out   <= '0;
      mode_err   <= 1'b0;
    end else begin
      if (acc) begin
        trip_valid <= 1'b1;
        trip_out   <= trip_nxt;
      end else if (trip_ready) begin
        trip_valid <= 1'b0;
      end
      if (acc && (|illegal)) mode_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instrumentation_trip_latch.sv
// Directed bench for instrumentation_trip_latch (DEBOUNCE=2) with
// hand-computed expected trip vectors, flags and channel states.
module tb_instrumentation_trip_latch;

  localparam logic [5:0] M_OPER   = 6'b01_01_01;
  localparam logic [5:0] M_BYPASS = 6'b00_00_00;
  localparam logic [5:0] M_TRIP   = 6'b10_10_10;
  localparam logic [5:0] M_MIX    = 6'b00_10_11;

  logic       clk;
  logic       rst_n;
  logic       sample_valid;
  logic       sample_ready;
  logic [2:0] sensor_trips;
  logic [5:0] modes;
  logic [2:0] reset_req;
  logic       trip_valid;
  logic       trip_ready;
  logic [2:0] trip_out;
  logic       mode_err;
  logic [5:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  instrumentation_trip_latch #(.DEBOUNCE(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sensor_trips (sensor_trips),
    .modes        (modes),
    .reset_req    (reset_req),
    .trip_valid   (trip_valid),
    .trip_ready   (trip_ready),
    .trip_out     (trip_out),
    .mode_err     (mode_err),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One accepted sample (trip_ready held high), outputs observed 1 ns after the edge.
  task automatic send(input logic [2:0] s, input logic [5:0] m, input logic [2:0] rr);
    sample_valid = 1'b1;
    sensor_trips = s;
    modes        = m;
    reset_req    = rr;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    reset_req    = 3'b000;
  endtask

  task automatic idle_cycle(input logic [2:0] rr);
    reset_req = rr;
    @(posedge clk);
    #1;
    reset_req = 3'b000;
  endtask

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sensor_trips = 3'b000;
    modes        = M_OPER;
    reset_req    = 3'b000;
    trip_ready   = 1'b1;
    #12;
    check("rst_trip_valid", 32'(trip_valid), 32'd0);
    check("rst_trip_out", 32'(trip_out), 32'd0);
    check("rst_mode_err", 32'(mode_err), 32'd0);
    check("rst_sample_ready", 32'(sample_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // debounce: two consecutive sensor hits latch channel 0
    send(3'b100, M_OPER, 3'b000);
    check("deb_s1_out", 32'(trip_out), 32'd0);
    check("deb_s1_valid", 32'(trip_valid), 32'd1);
    check("deb_s1_state", 32'(dbg_state), 32'h10);
    send(3'b100, M_OPER, 3'b000);
    check("deb_s2_out", 32'(trip_out), 32'h4);
    check("deb_s2_state", 32'(dbg_state), 32'h20);

    // reset while sensor active is ignored; reset with sensor quiet clears
    send(3'b100, M_OPER, 3'b100);
    check("rst_ignored", 32'(trip_out), 32'h4);
    send(3'b000, M_OPER, 3'b000);
    check("rst_consumed", 32'(trip_out), 32'h4);
    send(3'b000, M_OPER, 3'b100);
    check("rst_clears", 32'(trip_out), 32'h0);

    // interrupted debounce never latches
    send(3'b100, M_OPER, 3'b000);
    check("intr_a", 32'(trip_out), 32'h0);
    send(3'b000, M_OPER, 3'b000);
    check("intr_b", 32'(trip_out), 32'h0);
    send(3'b100, M_OPER, 3'b000);
    check("intr_c", 32'(trip_out), 32'h0);
    send(3'b000, M_OPER, 3'b000);

    // reset request pulsed with no sample offered, applied at next accept only
    send(3'b100, M_OPER, 3'b000);
    send(3'b100, M_OPER, 3'b000);
    check("pre_trip", 32'(trip_out), 32'h4);
    idle_cycle(3'b100);
    check("idle_valid_drop", 32'(trip_valid), 32'd0);
    check("idle_out_hold", 32'(trip_out), 32'h4);
    send(3'b000, M_OPER, 3'b000);
    check("pend_applied", 32'(trip_out), 32'h0);
    send(3'b100, M_OPER, 3'b000);
    send(3'b100, M_OPER, 3'b000);
    send(3'b000, M_OPER, 3'b000);
    check("pend_cleared", 32'(trip_out), 32'h4);
    send(3'b000, M_OPER, 3'b100);
    check("pend_final_clear", 32'(trip_out), 32'h0);

    // backpressure: output held, nothing accepted
    trip_ready   = 1'b0;
    sample_valid = 1'b1;
    sensor_trips = 3'b111;
    modes        = M_OPER;
    #1;
    check("bp_ready_comb", 32'(sample_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_out_%0d", i), 32'(trip_out), 32'h0);
      check($sformatf("bp_hold_valid_%0d", i), 32'(trip_valid), 32'd1);
      check($sformatf("bp_state_%0d", i), 32'(dbg_state), 32'h00);
    end
    trip_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(sample_ready), 32'd1);
    @(posedge clk);
    #1;
    check("b2b_1_out", 32'(trip_out), 32'h0);
    check("b2b_1_state", 32'(dbg_state), 32'h15);
    @(posedge clk);
    #1;
    check("b2b_2_out", 32'(trip_out), 32'h7);
    check("b2b_2_valid", 32'(trip_valid), 32'd1);
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_drain_valid", 32'(trip_valid), 32'd0);

    // bypass clears latched trips
    send(3'b111, M_BYPASS, 3'b000);
    check("bypass_clear", 32'(trip_out), 32'h0);
    check("bypass_no_err", 32'(mode_err), 32'd0);

    // mixed modes: bypass / manual trip / illegal
    send(3'b111, M_MIX, 3'b000);
    check("mix_out", 32'(trip_out), 32'h3);
    check("mix_err", 32'(mode_err), 32'd1);
    send(3'b000, M_OPER, 3'b000);
    check("mix_latched", 32'(trip_out), 32'h3);
    check("mix_err_sticky", 32'(mode_err), 32'd1);
    send(3'b000, M_BYPASS, 3'b000);
    check("mix_bypass", 32'(trip_out), 32'h0);
    check("mix_err_sticky2", 32'(mode_err), 32'd1);

    // asynchronous reset mid-transfer
    send(3'b000, M_TRIP, 3'b000);
    check("manual_trip", 32'(trip_out), 32'h7);
    trip_ready   = 1'b0;
    sample_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(trip_valid), 32'd0);
    check("arst_out", 32'(trip_out), 32'h0);
    check("arst_err", 32'(mode_err), 32'd0);
    check("arst_state", 32'(dbg_state), 32'h00);
    sample_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_ready", 32'(sample_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instrumentation_trip_latch.md
Name: instrumentation_trip_latch

Overview:
Downstream stage of the per-channel sensor trip comparators in the instrumentation unit. Consumes the NChannels-bit sensor trip vector and the per-channel mode word, one sample per valid/ready transfer. Applies mode override, debounce and trip latching per channel, then offers the latched trip vector to the voting logic over a valid/ready handshake. Trips are fail-safe: once latched, a trip clears only on an explicit maintenance reset while its cause is gone.

Parameters:
NChannels, 3, number of instrumentation channels; channel 0 maps to the MSB of every vector.
lg2, 2, width of one channel mode field.
DEBOUNCE, 2, consecutive accepted samples with sensor trip asserted (operate mode) before latching; legal range 1..15.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
sample_valid  in  1  upstream sample present.
sample_ready  out  1  block can accept a sample this cycle.
sensor_trips  in  NChannels  comparator results; bit NChannels-1-ch belongs to channel ch.
modes  in  NChannels*lg2  per-channel mode; field for ch is bits [lg2*(NChannels-ch)-1 -: lg2].
reset_req  in  NChannels  maintenance trip reset request per channel, same bit mapping; level or pulse.
trip_valid  out  1  trip_out holds a new result.
trip_ready  in  1  voting logic accepts trip_out.
trip_out  out  NChannels  latched trip vector, same bit mapping.
mode_err  out  1  sticky flag: an accepted sample carried mode 3.

Behaviour:
- Reset (rst_n low, asynchronous): trip_valid=0, trip_out=0, mode_err=0. Every channel is in IDLE with cnt=0, and rst_pend=0. sample_ready follows its rule below, so it is 1 after reset.
- Accept condition: acc = sample_valid & sample_ready, where sample_ready = !trip_valid | trip_ready.
- On acc, channel state updates and trip_out loads the new latched vector. trip_valid goes to 1 in the next cycle, giving a latency of 1 cycle.
- Output hold: if trip_valid & !trip_ready, trip_out and trip_valid hold and no sample is accepted. If trip_ready is high with no acc, trip_valid goes to 0.
- rst_pend[ch]:
  - Set on any cycle in which reset_req[ch]=1.
  - Consumed (cleared) on the next acc, whether or not the reset takes effect.
  - A reset_req arriving in the same cycle as acc is applied to that sample.
- Per-channel effective input on acc is decided by the mode value:
  - Mode 0 (bypass): channel goes to IDLE, cnt=0, trip bit 0. Bypass also clears a latched trip.
  - Mode 2 (manual trip): channel goes to TRIPPED immediately, with no debounce.
  - Mode 1 (operate): debounce on sensor_trips.
  - Mode 3 (illegal): treated as mode 2 (fail safe), and mode_err is set until rst_n.
- Per-channel FSM in operate mode, on acc only:
  - IDLE: if the sensor bit is 1, cnt=1. If DEBOUNCE=1, go to TRIPPED; otherwise go to PEND.
  - PEND: if the sensor bit is 1, cnt=cnt+1. When cnt reaches DEBOUNCE, go to TRIPPED. If the sensor bit is 0, go to IDLE with cnt=0.
  - TRIPPED: stays TRIPPED regardless of the sensor bit. If rst_pend[ch] is set and the sensor bit is 0, go to IDLE with cnt=0. If rst_pend[ch] is set and the sensor bit is 1, the reset is ignored (trip wins) and rst_pend[ch] is still consumed.
- A channel leaving mode 2 with its trip latched stays TRIPPED until a valid reset. Its reset condition is evaluated against the current sample's sensor bit.
- Trip bit is 1 iff the channel is in TRIPPED after the update; PEND reports 0.
- cnt has width 4 and saturates at DEBOUNCE; it never wraps.
- Back-to-back operation: when trip_ready is held at 1, one sample is accepted per cycle at full throughput.
- No combinational path from sample_valid to trip_valid. sample_ready depends combinationally on trip_ready only.

Decomposition:
- instrumentation_pkg: NChannels, lg2, a mode enum (MODE_BYPASS=0, MODE_OPERATE=1, MODE_TRIP=2, MODE_ILLEGAL=3), a channel FSM state enum (IDLE, PEND, TRIPPED), and a function extracting the field for ch from a packed vector.
- Sub-module trip_latch_channel: one channel FSM with cnt and rst_pend. Instantiated NChannels times by a generate loop.
- The top level holds the handshake, the output register and mode_err.

Test Plan:
- Reset: assert rst_n=0 mid-transfer with trip_valid=1 -> trip_out=0, trip_valid=0 and mode_err=0 immediately; sample_ready=1 after release.
- Debounce (DEBOUNCE=2, all modes 1, trip_ready=1): sensor_trips 3'b100 for samples 1 and 2 -> trip_out 3'b000 after sample 1 and 3'b100 after sample 2. Pattern 3'b100, 3'b000, 3'b100 -> trip_out never sets.
- Latch and reset: channel 0 tripped; reset_req=3'b100 with sensor 3'b100 -> trip_out stays 3'b100. Next reset_req with sensor 3'b000 -> trip_out 3'b000.
- Modes: modes={2'h0,2'h2,2'h3} with sensor_trips 3'b111 -> trip_out 3'b011 after one sample, and mode_err=1 and stays 1.
- Backpressure: trip_ready=0 for 4 cycles with sample_valid=1 -> sample_ready=0 and trip_out held stable. Then trip_ready=1 -> one sample per cycle with 1-cycle latency.
- Reset request before acceptance: reset_req pulses while no sample is offered -> applied at the next accepted sample only, then cleared.
